i2c_wb_xfer_seq: RTL

- Transaction sequencer that sits directly upstream of the I2C master core's Wishbone slave port.
- Converts one request (7-bit slave address, direction, byte count) plus a byte stream into the register-access sequence on PRER/CTR/TXR/RXR/CR/SR.
- Polls SR, checks RxACK and AL, and reports a per-transfer status.
- Replaces hand-written register sequences in firmware-style directed tests and serves as a synthesizable host front end.

---
 rtl/i2c_wb_seq_pkg.sv | 77 +++++++
 rtl/i2c_wb_single_master.sv | 93 +++++++++
 rtl/i2c_wb_xfer_seq.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_wb_seq_pkg.sv
// Shared definitions for the I2C Wishbone transfer sequencer.
// Contents: I2C master core register addresses, CR/SR bit positions,
// the CR command bytes used by the sequencer, and the status, state and
// poll-context enums.
package i2c_wb_seq_pkg;

    // Register map of the I2C master core (TXR/RXR and CR/SR share addresses)
    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_RXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [2:0] ADR_SR     = 3'd4;

    // Command register bits
    localparam int CR_STA = 7;
    localparam int CR_STO = 6;
    localparam int CR_RD  = 5;
    localparam int CR_WR  = 4;
    localparam int CR_ACK = 3;

    // Status register bits
    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    // Control register value: core enable
    localparam logic [7:0] CTR_EN = 8'h80;

    // Command bytes
    localparam logic [7:0] CMD_STA_WR      = 8'((8'd1 << CR_STA) | (8'd1 << CR_WR));                    // 0x90
    localparam logic [7:0] CMD_STA_WR_STO  = 8'((8'd1 << CR_STA) | (8'd1 << CR_STO) | (8'd1 << CR_WR)); // 0xD0
    localparam logic [7:0] CMD_WR          = 8'(8'd1 << CR_WR);                                        // 0x10
    localparam logic [7:0] CMD_WR_STO      = 8'((8'd1 << CR_STO) | (8'd1 << CR_WR));                    // 0x50
    localparam logic [7:0] CMD_RD          = 8'(8'd1 << CR_RD);                                        // 0x20
    localparam logic [7:0] CMD_RD_NACK_STO = 8'((8'd1 << CR_STO) | (8'd1 << CR_RD) | (8'd1 << CR_ACK)); // 0x68
    localparam logic [7:0] CMD_STO         = 8'(8'd1 << CR_STO);                                       // 0x40

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_NACK    = 2'd1,
        ST_ARBLOST = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_t;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT_LO  = 4'd1,
        S_INIT_HI  = 4'd2,
        S_INIT_EN  = 4'd3,
        S_ADDR_TXR = 4'd4,
        S_ADDR_CR  = 4'd5,
        S_POLL     = 4'd6,
        S_WR_WAIT  = 4'd7,
        S_WR_TXR   = 4'd8,
        S_WR_CR    = 4'd9,
        S_RD_CR    = 4'd10,
        S_RD_RXR   = 4'd11,
        S_RD_WAIT  = 4'd12,
        S_STOP     = 4'd13,
        S_DONE     = 4'd14
    } state_t;

    // What the current SR poll loop is waiting on
    typedef enum logic [1:0] {
        PK_ADDR = 2'd0,
        PK_WR   = 2'd1,
        PK_RD   = 2'd2
    } poll_kind_t;

    // True when a CR command already requests a STOP condition
    function automatic logic cmd_has_sto(input logic [7:0] cmd);
        return cmd[CR_STO];
    endfunction

endpackage

// File: rtl/i2c_wb_single_master.sv
// One-access Wishbone master handshake engine.
// start/addr/we/wdata launch a single access when idle; cyc/stb/adr/dat/we
// are held until ack. On the ack cycle read data is captured and cyc/stb
// drop; done pulses on the following cycle with rdata valid.
// Ports: wb_clk_i, arst_i (async active-low), start, addr, we, wdata,
//        busy, rdata, done, wbm_* Wishbone master signals.
module i2c_wb_single_master
    import i2c_wb_seq_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       start,
    input  logic [2:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       done,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    logic       cyc_q, cyc_d;
    logic [2:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic       we_q, we_d;
    logic [7:0] rdata_q, rdata_d;
    logic       done_q, done_d;

    // Next-state logic for the single access handshake
    always_comb begin
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        if (cyc_q) begin
            if (wbm_ack_i) begin
                cyc_d  = 1'b0;
                done_d = 1'b1;
                if (!we_q) begin
                    rdata_d = wbm_dat_i;
                end else begin
                    rdata_d = rdata_q;
                end
            end else begin
                cyc_d = 1'b1;
            end
        end else if (start) begin
            cyc_d = 1'b1;
            adr_d = addr;
            we_d  = we;
            dat_d = wdata;
        end else begin
            cyc_d = 1'b0;
        end
    end

    // Handshake registers
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            cyc_q   <= 1'b0;
            adr_q   <= 3'd0;
            dat_q   <= 8'h00;
            we_q    <= 1'b0;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign busy      = cyc_q;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;

endmodule

// File: rtl/i2c_wb_xfer_seq.sv
// I2C transfer sequencer driving the I2C master core's Wishbone slave port.
// Accepts one request (address, direction, length), runs core init once,
// then the ADDR/WR/RD register sequences with SR polling, and reports a
// per-transfer status with a one-cycle done pulse.
// Ports: wb_clk_i, arst_i (async active-low), cfg_prescale,
//        req_valid/req_ready/req_addr/req_rd/req_len   request channel,
//        wr_data/wr_valid/wr_ready                      write byte stream,
//        rd_data/rd_valid/rd_ready                      read byte stream,
//        done, status                                   completion,
//        wbm_*                                          Wishbone master.
module i2c_wb_xfer_seq
    import i2c_wb_seq_pkg::*;
#(
    parameter int POLL_TIMEOUT = 4096,
    parameter int TO_W         = 16
) (
    input  logic        wb_clk_i,
    input  logic        arst_i,
    input  logic [15:0] cfg_prescale,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_addr,
    input  logic        req_rd,
    input  logic [7:0]  req_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic [1:0]  status,
    output logic [2:0]  wbm_adr_o,
    output logic [7:0]  wbm_dat_o,
    input  logic [7:0]  wbm_dat_i,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(POLL_TIMEOUT);

    state_t          state_q, state_d;
    status_t         status_q, status_d;
    poll_kind_t      kind_q, kind_d;
    logic            init_done_q, init_done_d;
    logic [6:0]      addr_q, addr_d;
    logic            rd_q, rd_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      wbyte_q, wbyte_d;
    logic [7:0]      last_cr_q, last_cr_d;
    logic            pend_q, pend_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            wr_ready_q, wr_ready_d;
    logic            rd_valid_q, rd_valid_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            done_q, done_d;

    logic            acc_state_s;
    logic            m_start_s;
    logic [2:0]      m_adr_s;
    logic            m_we_s;
    logic [7:0]      m_wdata_s;
    logic [7:0]      m_rdata_s;
    logic            m_busy_s;
    logic            m_done_s;

    i2c_wb_single_master u_wbm (
        .wb_clk_i  (wb_clk_i),
        .arst_i    (arst_i),
        .start     (m_start_s),
        .addr      (m_adr_s),
        .we        (m_we_s),
        .wdata     (m_wdata_s),
        .busy      (m_busy_s),
        .rdata     (m_rdata_s),
        .done      (m_done_s),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_we_o  (wbm_we_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_ack_i (wbm_ack_i)
    );

    // Wishbone access descriptor for the current state; one access per visit
    always_comb begin
        acc_state_s = 1'b1;
        m_adr_s     = ADR_CR;
        m_we_s      = 1'b1;
        m_wdata_s   = 8'h00;
        case (state_q)
            S_INIT_LO:  begin m_adr_s = ADR_PRERLO; m_wdata_s = cfg_prescale[7:0]; end
            S_INIT_HI:  begin m_adr_s = ADR_PRERHI; m_wdata_s = cfg_prescale[15:8]; end
            S_INIT_EN:  begin m_adr_s = ADR_CTR;    m_wdata_s = CTR_EN; end
            S_ADDR_TXR: begin m_adr_s = ADR_TXR;    m_wdata_s = {addr_q, rd_q}; end
            S_ADDR_CR:  m_wdata_s = (cnt_q == 8'd0) ? CMD_STA_WR_STO : CMD_STA_WR;
            S_POLL:     begin m_adr_s = ADR_SR;     m_we_s = 1'b0; end
            S_WR_TXR:   begin m_adr_s = ADR_TXR;    m_wdata_s = wbyte_q; end
            S_WR_CR:    m_wdata_s = (cnt_q == 8'd1) ? CMD_WR_STO : CMD_WR;
            S_RD_CR:    m_wdata_s = (cnt_q == 8'd1) ? CMD_RD_NACK_STO : CMD_RD;
            S_RD_RXR:   begin m_adr_s = ADR_RXR;    m_we_s = 1'b0; end
            S_STOP:     m_wdata_s = CMD_STO;
            default:    acc_state_s = 1'b0;
        endcase
        m_start_s = acc_state_s && !pend_q && !m_busy_s;
    end

    // Sequencer next-state and output logic
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        kind_d      = kind_q;
        init_done_d = init_done_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        wbyte_d     = wbyte_q;
        wr_ready_d  = 1'b0;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;

        // pend marks an access launched but not yet completed in this state
        if (m_start_s) begin
            pend_d = 1'b1;
        end else if (m_done_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        // Remember the last CR command so a NACK knows whether STOP already went out
        if (m_start_s && m_we_s && (m_adr_s == ADR_CR)) begin
            last_cr_d = m_wdata_s;
        end else begin
            last_cr_d = last_cr_q;
        end

        // Poll budget restarts every time POLL is entered; saturates at the limit
        if (state_q == S_POLL) begin
            to_cnt_d = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d   = req_addr;
                    rd_d     = req_rd;
                    cnt_d    = req_len;
                    status_d = ST_OK;
                    state_d  = init_done_q ? S_ADDR_TXR : S_INIT_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT_LO: begin
                if (m_done_s) state_d = S_INIT_HI;
                else          state_d = S_INIT_LO;
            end
            S_INIT_HI: begin
                if (m_done_s) state_d = S_INIT_EN;
                else          state_d = S_INIT_HI;
            end
            S_INIT_EN: begin
                if (m_done_s) begin
                    init_done_d = 1'b1;
                    state_d     = S_ADDR_TXR;
                end else begin
                    state_d = S_INIT_EN;
                end
            end
            S_ADDR_TXR: begin
                if (m_done_s) state_d = S_ADDR_CR;
                else          state_d = S_ADDR_TXR;
            end
            S_ADDR_CR: begin
                if (m_done_s) begin
                    kind_d  = PK_ADDR;
                    state_d = S_POLL;
                end else begin
                    state_d = S_ADDR_CR;
                end
            end
            S_POLL: begin
                if (m_done_s) begin
                    if (!m_rdata_s[SR_TIP]) begin
                        if (m_rdata_s[SR_AL]) begin
                            status_d = ST_ARBLOST;
                            state_d  = S_DONE;
                        end else if (m_rdata_s[SR_RXACK] && (kind_q != PK_RD)) begin
                            status_d = ST_NACK;
                            state_d  = cmd_has_sto(last_cr_q) ? S_DONE : S_STOP;
                        end else begin
                            case (kind_q)
                                PK_ADDR: begin
                                    if (cnt_q == 8'd0)  state_d = S_DONE;
                                    else if (rd_q)      state_d = S_RD_CR;
                                    else                state_d = S_WR_WAIT;
                                end
                                PK_WR: begin
                                    cnt_d   = cnt_q - 8'd1;
                                    state_d = (cnt_q == 8'd1) ? S_DONE : S_WR_WAIT;
                                end
                                PK_RD:   state_d = S_RD_RXR;
                                default: state_d = S_DONE;
                            endcase
                        end
                    end else if (to_cnt_q >= TO_LIMIT) begin
                        status_d = ST_TIMEOUT;
                        state_d  = S_STOP;
                    end else begin
                        state_d = S_POLL;
                    end
                end else begin
                    state_d = S_POLL;
                end
            end
            S_WR_WAIT: begin
                // wr_ready is high in the cycle whose closing edge latches wr_data
                if (wr_ready_q) begin
                    wbyte_d = wr_data;
                    state_d = S_WR_TXR;
                end else if (wr_valid) begin
                    wr_ready_d = 1'b1;
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_TXR: begin
                if (m_done_s) state_d = S_WR_CR;
                else          state_d = S_WR_TXR;
            end
            S_WR_CR: begin
                if (m_done_s) begin
                    kind_d  = PK_WR;
                    state_d = S_POLL;
                end else begin
                    state_d = S_WR_CR;
                end
            end
            S_RD_CR: begin
                if (m_done_s) begin
                    kind_d  = PK_RD;
                    state_d = S_POLL;
                end else begin
                    state_d = S_RD_CR;
                end
            end
            S_RD_RXR: begin
                if (m_done_s) begin
                    rd_data_d  = m_rdata_s;
                    rd_valid_d = 1'b1;
                    state_d    = S_RD_WAIT;
                end else begin
                    state_d = S_RD_RXR;
                end
            end
            S_RD_WAIT: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    cnt_d      = cnt_q - 8'd1;
                    state_d    = (cnt_q == 8'd1) ? S_DONE : S_RD_CR;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_STOP: begin
                if (m_done_s) state_d = S_DONE;
                else          state_d = S_STOP;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q     <= S_IDLE;
            status_q    <= ST_OK;
            kind_q      <= PK_ADDR;
            init_done_q <= 1'b0;
            addr_q      <= 7'd0;
            rd_q        <= 1'b0;
            cnt_q       <= 8'd0;
            wbyte_q     <= 8'h00;
            last_cr_q   <= 8'h00;
            pend_q      <= 1'b0;
            to_cnt_q    <= {TO_W{1'b0}};
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            kind_q      <= kind_d;
            init_done_q <= init_done_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            wbyte_q     <= wbyte_d;
            last_cr_q   <= last_cr_d;
            pend_q      <= pend_d;
            to_cnt_q    <= to_cnt_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign status    = status_q;

endmodule
